csr_access_unit: RTL and testbench

//   Executes Zicsr instructions (CSRRW/RS/RC and immediate forms) for the execute stage.

---
 rtl/csr_access_unit.sv | 184 ++++++++++++++++++
 tb/tb_csr_access_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_access_unit
// Description : Zicsr execute unit (CSRRW/RS/RC and immediate forms).
//               Accepts one decoded CSR op per handshake, reads the old CSR
//               value from csregfile, and computes the new value. It then
//               issues the CSR write and returns the old value on the rd
//               write port. Each op occupies IDLE -> READ -> WRITE.
// Ports       : clk, rst (async, active-high)
//               op_valid/op_ready handshake, op_funct3, op_csr_addr,
//               op_rs1_data, op_rs1_idx, op_rd   - decoded op
//               csr_raddr / csr_rdata            - CSR read (combinational)
//               csr_waddr / csr_wdata            - CSR write (CSR_NONE = none)
//               rd_waddr / rd_wdata              - GPR write (0 = none)
//               done, illegal                    - retire pulses
// Revision    : 1.0 - initial release
// ============================================================================
module csr_access_unit #(
    parameter int                    CSR_ADDR_W = 12,
    parameter int                    DATA_W     = 32,
    parameter logic [CSR_ADDR_W-1:0] CSR_NONE   = 12'h000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_funct3,
    input  logic [CSR_ADDR_W-1:0] op_csr_addr,
    input  logic [DATA_W-1:0]     op_rs1_data,
    input  logic [4:0]            op_rs1_idx,
    input  logic [4:0]            op_rd,
    output logic [CSR_ADDR_W-1:0] csr_raddr,
    input  logic [DATA_W-1:0]     csr_rdata,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0]     csr_wdata,
    output logic [4:0]            rd_waddr,
    output logic [DATA_W-1:0]     rd_wdata,
    output logic                  done,
    output logic                  illegal
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [2:0]              funct3_q,   funct3_d;
    logic [CSR_ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]       rs1_data_q, rs1_data_d;
    logic [4:0]              rs1_idx_q,  rs1_idx_d;
    logic [4:0]              rd_q,       rd_d;
    logic [DATA_W-1:0]       old_q,      old_d;
    logic [DATA_W-1:0]       new_q,      new_d;
    logic                    illegal_q,  illegal_d;
    logic                    wen_q,      wen_d;

    logic [DATA_W-1:0]       w_src;
    logic [DATA_W-1:0]       w_new;
    logic                    w_no_write;
    logic                    w_illegal;

    // Operand source and new-value computation, evaluated while in READ
    // against the live csr_rdata.
    always_comb begin
        w_src      = op_src(funct3_q[2], rs1_data_q, rs1_idx_q);
        // Set/clear forms with x0 / zimm=0 are pure reads: no CSR side effect.
        w_no_write = funct3_q[1] && (rs1_idx_q == 5'd0);
        case (funct3_q[1:0])
            2'b10:   w_new = csr_rdata | w_src;
            2'b11:   w_new = csr_rdata & ~w_src;
            default: w_new = w_src;
        endcase
        // Top two address bits 11 mark read-only CSRs; only an actual write
        // to them is rejected, a pure read is legal.
        w_illegal  = (funct3_q[1:0] == 2'b00) ||
                     (addr_q == CSR_NONE) ||
                     ((addr_q[CSR_ADDR_W-1:CSR_ADDR_W-2] == 2'b11) && !w_no_write);
    end

    function automatic logic [DATA_W-1:0] op_src(input logic            imm,
                                                 input logic [DATA_W-1:0] data,
                                                 input logic [4:0]        idx);
        if (imm) begin
            op_src = {{(DATA_W-5){1'b0}}, idx};
        end else begin
            op_src = data;
        end
    endfunction

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        rs1_data_d = rs1_data_q;
        rs1_idx_d  = rs1_idx_q;
        rd_d       = rd_q;
        old_d      = old_q;
        new_d      = new_q;
        illegal_d  = illegal_q;
        wen_d      = wen_q;

        op_ready   = 1'b0;
        csr_raddr  = CSR_NONE;
        csr_waddr  = CSR_NONE;
        csr_wdata  = '0;
        rd_waddr   = 5'd0;
        rd_wdata   = '0;
        done       = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    funct3_d   = op_funct3;
                    addr_d     = op_csr_addr;
                    rs1_data_d = op_rs1_data;
                    rs1_idx_d  = op_rs1_idx;
                    rd_d       = op_rd;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                csr_raddr = addr_q;
                old_d     = csr_rdata;
                new_d     = w_new;
                illegal_d = w_illegal;
                wen_d     = !w_illegal && !w_no_write;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                done    = 1'b1;
                illegal = illegal_q;
                if (wen_q) begin
                    csr_waddr = addr_q;
                    csr_wdata = new_q;
                end
                if (!illegal_q) begin
                    rd_waddr = rd_q;
                end
                // csregfile ORs its write sources, so data must be zero
                // whenever no register write is requested.
                if (!illegal_q && (rd_q != 5'd0)) begin
                    rd_wdata = old_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            funct3_q   <= 3'd0;
            addr_q     <= CSR_NONE;
            rs1_data_q <= '0;
            rs1_idx_q  <= 5'd0;
            rd_q       <= 5'd0;
            old_q      <= '0;
            new_q      <= '0;
            illegal_q  <= 1'b0;
            wen_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            rs1_data_q <= rs1_data_d;
            rs1_idx_q  <= rs1_idx_d;
            rd_q       <= rd_d;
            old_q      <= old_d;
            new_q      <= new_d;
            illegal_q  <= illegal_d;
            wen_q      <= wen_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_access_unit
// Description : Self-checking bench for csr_access_unit. A table of CSR ops
//               with hand-computed results is applied in a loop. Expected
//               results are queued at accept and compared when done pulses.
//               Hand-written sequences cover reset state and reset mid-op.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_access_unit;

    localparam logic [11:0] C_NONE = 12'h000;
    localparam int          C_NVEC = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_funct3;
    logic [11:0] op_csr_addr;
    logic [31:0] op_rs1_data;
    logic [4:0]  op_rs1_idx;
    logic [4:0]  op_rd;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        done;
    logic        illegal;

    csr_access_unit #(
        .CSR_ADDR_W (12),
        .DATA_W     (32),
        .CSR_NONE   (12'h000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_funct3   (op_funct3),
        .op_csr_addr (op_csr_addr),
        .op_rs1_data (op_rs1_data),
        .op_rs1_idx  (op_rs1_idx),
        .op_rd       (op_rd),
        .csr_raddr   (csr_raddr),
        .csr_rdata   (csr_rdata),
        .csr_waddr   (csr_waddr),
        .csr_wdata   (csr_wdata),
        .rd_waddr    (rd_waddr),
        .rd_wdata    (rd_wdata),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  idx;
        logic [4:0]  rd;
        logic [31:0] old;
        logic        hold;
        logic [11:0] e_waddr;
        logic [31:0] e_wdata;
        logic [4:0]  e_rdw;
        logic [31:0] e_rdd;
        logic        e_ill;
    } vec_t;

    typedef struct {
        int          id;
        logic [11:0] e_waddr;
        logic [31:0] e_wdata;
        logic [4:0]  e_rdw;
        logic [31:0] e_rdd;
        logic        e_ill;
    } exp_t;

    vec_t vecs [C_NVEC];
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_ready"},  {31'd0, op_ready}, 32'd1);
        check({tag, "_csr_raddr"}, {20'd0, csr_raddr}, {20'd0, C_NONE});
        check({tag, "_csr_waddr"}, {20'd0, csr_waddr}, {20'd0, C_NONE});
        check({tag, "_csr_wdata"}, csr_wdata, 32'd0);
        check({tag, "_rd_waddr"},  {27'd0, rd_waddr}, 32'd0);
        check({tag, "_rd_wdata"},  rd_wdata, 32'd0);
        check({tag, "_done"},      {31'd0, done}, 32'd0);
        check({tag, "_illegal"},   {31'd0, illegal}, 32'd0);
    endtask

    // Scoreboard: every done pulse retires the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, required no retire pending");
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_csr_waddr", e.id), {20'd0, csr_waddr}, {20'd0, e.e_waddr});
                check($sformatf("v%0d_csr_wdata", e.id), csr_wdata, e.e_wdata);
                check($sformatf("v%0d_rd_waddr", e.id),  {27'd0, rd_waddr}, {27'd0, e.e_rdw});
                check($sformatf("v%0d_rd_wdata", e.id),  rd_wdata, e.e_rdd);
                check($sformatf("v%0d_illegal", e.id),   {31'd0, illegal}, {31'd0, e.e_ill});
            end
        end
    end

    // Drives one op through a full IDLE->READ->WRITE->IDLE pass, acting as
    // csregfile for the read. With do_rst, reset is asserted during READ.
    task automatic run_op(input int id, input vec_t v, input bit do_rst);
        exp_t e;
        @(negedge clk);
        op_valid    = 1'b1;
        op_funct3   = v.f3;
        op_csr_addr = v.addr;
        op_rs1_data = v.rs1;
        op_rs1_idx  = v.idx;
        op_rd       = v.rd;
        #1;
        check($sformatf("v%0d_ready_idle", id), {31'd0, op_ready}, 32'd1);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_ready_read", id), {31'd0, op_ready}, 32'd0);
        check($sformatf("v%0d_raddr_read", id), {20'd0, csr_raddr}, {20'd0, v.addr});
        csr_rdata = v.old;
        if (!v.hold) begin
            op_valid = 1'b0;
        end
        if (do_rst) begin
            rst = 1'b1;
            #1;
            check_reset_outputs($sformatf("v%0d_rst_mid", id));
            op_valid  = 1'b0;
            csr_rdata = 32'd0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        e.id      = id;
        e.e_waddr = v.e_waddr;
        e.e_wdata = v.e_wdata;
        e.e_rdw   = v.e_rdw;
        e.e_rdd   = v.e_rdd;
        e.e_ill   = v.e_ill;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_done_lat", id),    {31'd0, done}, 32'd1);
        check($sformatf("v%0d_raddr_write", id), {20'd0, csr_raddr}, {20'd0, C_NONE});
        // Old value is only valid during READ; garbage here must not leak.
        csr_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        check($sformatf("v%0d_done_off", id),    {31'd0, done}, 32'd0);
        check($sformatf("v%0d_ready_after", id), {31'd0, op_ready}, 32'd1);
        op_valid = 1'b0;
    endtask

    initial begin
        //            f3      addr     rs1_data      idx    rd     old          hold  e_waddr  e_wdata       e_rdw  e_rdd         ill
        vecs[0]  = '{3'b001, 12'h340, 32'hDEADBEEF, 5'd1,  5'd5,  32'h12345678, 1'b0, 12'h340, 32'hDEADBEEF, 5'd5,  32'h12345678, 1'b0};
        vecs[1]  = '{3'b010, 12'h300, 32'h0000FFFF, 5'd0,  5'd7,  32'h00000088, 1'b0, C_NONE,  32'h0,        5'd7,  32'h00000088, 1'b0};
        vecs[2]  = '{3'b111, 12'h340, 32'h0000AAAA, 5'h0F, 5'd1,  32'h000000FF, 1'b0, 12'h340, 32'h000000F0, 5'd1,  32'h000000FF, 1'b0};
        vecs[3]  = '{3'b001, 12'hF11, 32'h00000001, 5'd2,  5'd3,  32'h00000005, 1'b0, C_NONE,  32'h0,        5'd0,  32'h0,        1'b1};
        vecs[4]  = '{3'b010, 12'hF11, 32'h00000055, 5'd0,  5'd4,  32'h0000ABCD, 1'b0, C_NONE,  32'h0,        5'd4,  32'h0000ABCD, 1'b0};
        vecs[5]  = '{3'b100, 12'h340, 32'h00000001, 5'd1,  5'd6,  32'h00000007, 1'b1, C_NONE,  32'h0,        5'd0,  32'h0,        1'b1};
        vecs[6]  = '{3'b000, 12'h340, 32'h00000001, 5'd1,  5'd6,  32'h00000007, 1'b0, C_NONE,  32'h0,        5'd0,  32'h0,        1'b1};
        vecs[7]  = '{3'b001, C_NONE,  32'h00000001, 5'd1,  5'd6,  32'h00000007, 1'b0, C_NONE,  32'h0,        5'd0,  32'h0,        1'b1};
        vecs[8]  = '{3'b001, 12'h341, 32'h00001234, 5'd3,  5'd0,  32'h00000099, 1'b1, 12'h341, 32'h00001234, 5'd0,  32'h0,        1'b0};
        vecs[9]  = '{3'b010, 12'h300, 32'h000000F0, 5'd9,  5'd2,  32'h0000000F, 1'b0, 12'h300, 32'h000000FF, 5'd2,  32'h0000000F, 1'b0};
        vecs[10] = '{3'b011, 12'h304, 32'h000000FF, 5'd8,  5'd10, 32'h00000F0F, 1'b0, 12'h304, 32'h00000F00, 5'd10, 32'h00000F0F, 1'b0};
        vecs[11] = '{3'b101, 12'h305, 32'hFFFFFFFF, 5'd31, 5'd11, 32'h00000001, 1'b0, 12'h305, 32'h0000001F, 5'd11, 32'h00000001, 1'b0};
        vecs[12] = '{3'b110, 12'h340, 32'h00000000, 5'h10, 5'd12, 32'h00000003, 1'b0, 12'h340, 32'h00000013, 5'd12, 32'h00000003, 1'b0};
        vecs[13] = '{3'b011, 12'h340, 32'h0000FFFF, 5'd0,  5'd13, 32'h00000077, 1'b0, C_NONE,  32'h0,        5'd13, 32'h00000077, 1'b0};
        vecs[14] = '{3'b110, 12'hC00, 32'h00000000, 5'd0,  5'd14, 32'h00000042, 1'b0, C_NONE,  32'h0,        5'd14, 32'h00000042, 1'b0};
        vecs[15] = '{3'b101, 12'hC00, 32'h00000000, 5'd4,  5'd15, 32'h00000042, 1'b1, C_NONE,  32'h0,        5'd0,  32'h0,        1'b1};

        rst         = 1'b1;
        op_valid    = 1'b0;
        op_funct3   = 3'd0;
        op_csr_addr = 12'h000;
        op_rs1_data = 32'd0;
        op_rs1_idx  = 5'd0;
        op_rd       = 5'd0;
        csr_rdata   = 32'd0;

        // Reset held across clock edges must keep every output at rest,
        // even with an op offered.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < C_NVEC; i++) begin
            run_op(i, vecs[i], 1'b0);
        end

        // Reset during READ drops the op; the next op must be unaffected.
        run_op(100, vecs[10], 1'b1);
        #1;
        check_reset_outputs("post_rst");
        run_op(101, vecs[0], 1'b0);
        run_op(102, vecs[2], 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
